// File: rtl/inst_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_pkg : shared opcode constants, instruction field layout and helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
package inst_pkg;

  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JMPC = 4'hD;

  localparam int OPC_LSB  = 12;
  localparam int RD_LSB   = 9;
  localparam int FLAG_BIT = 8;
  localparam int RA_LSB   = 5;
  localparam int RB_LSB   = 2;
  localparam int IMM_W    = 8;

  typedef struct packed {
    logic [4:0]  aluop;
    logic [2:0]  sel_d;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [15:0] imm;
    logic        regwe;
  } fields_t;

  function automatic logic is_imm_form(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_JMP);
  endfunction

  function automatic logic exp_regwe(input logic [3:0] op);
    return !((op == OP_ST) || (op == OP_JMP) || (op == OP_JMPC));
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_enc_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_enc_pack : combinational field packer, fields -> {word, consistency err}.
// Rev 1.0
// ---------------------------------------------------------------------------
module inst_enc_pack
  import inst_pkg::*;
(
  input  fields_t     f_i,
  output logic [15:0] inst_o,
  output logic        err_o
);

  logic [3:0] w_op;
  logic       w_imm_form;
  logic       w_imm_bad;

  always_comb begin
    w_op       = f_i.aluop[4:1];
    w_imm_form = is_imm_form(w_op);
    // Immediate form carries the byte twice; the halves must agree.
    w_imm_bad  = w_imm_form && (f_i.imm[2*IMM_W-1:IMM_W] != f_i.imm[IMM_W-1:0]);

    inst_o                   = '0;
    inst_o[OPC_LSB +: 4]     = w_op;
    inst_o[RD_LSB +: 3]      = f_i.sel_d;
    inst_o[FLAG_BIT]         = f_i.aluop[0];
    if (w_imm_form) begin
      inst_o[IMM_W-1:0]      = f_i.imm[IMM_W-1:0];
    end else begin
      inst_o[RA_LSB +: 3]    = f_i.sel_a;
      inst_o[RB_LSB +: 3]    = f_i.sel_b;
    end

    err_o = w_imm_bad || (f_i.regwe != exp_regwe(w_op));
  end

endmodule
`default_nettype wire

// File: rtl/inst_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_enc : 2-stage valid/ready instruction encoder with program-memory
//            address counter.
// Rev 1.0
// ---------------------------------------------------------------------------
module inst_enc
  import inst_pkg::*;
#(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          I_Clk,
  input  logic          I_Rst,
  input  logic          I_En,
  input  logic          I_Clr,
  input  logic          I_Valid,
  output logic          O_Ready,
  input  logic [4:0]    I_Aluop,
  input  logic [2:0]    I_SelD,
  input  logic [2:0]    I_SelA,
  input  logic [2:0]    I_SelB,
  input  logic [15:0]   I_Imm,
  input  logic          I_Regwe,
  output logic          O_Valid,
  input  logic          I_Ready,
  output logic [15:0]   O_Inst,
  output logic [AW-1:0] O_Addr,
  output logic          O_Err,
  output logic          O_Wrap
);

  fields_t       s1_q, s1_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic [15:0]   s2_inst_q, s2_inst_d;
  logic          s2_err_q, s2_err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wrap_q, wrap_d;

  fields_t       w_fields;
  logic [15:0]   w_pack_inst;
  logic          w_pack_err;
  logic          w_out_xfer, w_in_xfer, w_s2_load, w_s1_move;

  assign w_fields = '{aluop: I_Aluop, sel_d: I_SelD, sel_a: I_SelA,
                      sel_b: I_SelB, imm: I_Imm, regwe: I_Regwe};

  inst_enc_pack u_pack (
    .f_i    (s1_q),
    .inst_o (w_pack_inst),
    .err_o  (w_pack_err)
  );

  // Each stage may load in the same cycle the stage ahead of it drains.
  assign w_out_xfer = I_En & s2_valid_q & I_Ready;
  assign w_s2_load  = I_En & (~s2_valid_q | w_out_xfer);
  assign w_s1_move  = s1_valid_q & w_s2_load;
  assign O_Ready    = ~I_Rst & I_En & (~s1_valid_q | w_s2_load);
  assign w_in_xfer  = I_Valid & O_Ready;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_err_d   = s2_err_q;
    addr_d     = addr_q;
    wrap_d     = 1'b0;

    if (w_s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_d = w_pack_inst;
        s2_err_d  = w_pack_err;
      end
    end

    if (w_in_xfer) begin
      s1_valid_d = 1'b1;
      s1_d       = w_fields;
    end else if (w_s1_move) begin
      s1_valid_d = 1'b0;
    end

    // A clear wins over the increment; the transferred word is still consumed.
    if (I_En & I_Clr) begin
      addr_d = BASE_ADDR;
    end else if (w_out_xfer) begin
      addr_d = addr_q + 1'b1;
      wrap_d = (addr_q == '1);
    end
  end

  always_ff @(posedge I_Clk) begin
    if (I_Rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      wrap_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_err_q   <= s2_err_d;
      addr_q     <= addr_d;
      wrap_q     <= wrap_d;
    end
  end

  assign O_Valid = s2_valid_q;
  assign O_Inst  = s2_inst_q;
  assign O_Err   = s2_err_q;
  assign O_Addr  = addr_q;
  assign O_Wrap  = wrap_q & I_En;

endmodule
`default_nettype wire

// File: tb/tb_inst_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_enc : directed self-checking bench for inst_enc.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_inst_enc;

  localparam logic [7:0] BASE = 8'h10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, clr, valid, ready, valid2, ready2, regwe;
  logic [4:0]  aluop;
  logic [2:0]  sd, sa, sb;
  logic [15:0] imm;

  logic        o_ready, o_valid, o_err, o_wrap;
  logic [15:0] o_inst;
  logic [7:0]  o_addr;
  logic        o_ready2, o_valid2, o_err2, o_wrap2;
  logic [15:0] o_inst2;
  logic [1:0]  o_addr2;

  inst_enc #(.AW(8), .BASE_ADDR(BASE)) u_dut (
    .I_Clk(clk), .I_Rst(rst), .I_En(en), .I_Clr(clr),
    .I_Valid(valid), .O_Ready(o_ready),
    .I_Aluop(aluop), .I_SelD(sd), .I_SelA(sa), .I_SelB(sb),
    .I_Imm(imm), .I_Regwe(regwe),
    .O_Valid(o_valid), .I_Ready(ready), .O_Inst(o_inst),
    .O_Addr(o_addr), .O_Err(o_err), .O_Wrap(o_wrap)
  );

  inst_enc #(.AW(2), .BASE_ADDR(2'd2)) u_wrap (
    .I_Clk(clk), .I_Rst(rst), .I_En(en), .I_Clr(clr),
    .I_Valid(valid2), .O_Ready(o_ready2),
    .I_Aluop(aluop), .I_SelD(sd), .I_SelA(sa), .I_SelB(sb),
    .I_Imm(imm), .I_Regwe(regwe),
    .O_Valid(o_valid2), .I_Ready(ready2), .O_Inst(o_inst2),
    .O_Addr(o_addr2), .O_Err(o_err2), .O_Wrap(o_wrap2)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] exp_addr;

  logic [4:0]  t_aluop [4];
  logic [2:0]  t_d [4];
  logic [15:0] t_inst [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a, input logic [2:0] d, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [15:0] im, input logic we);
    aluop = a; sd = d; sa = ra; sb = rb; imm = im; regwe = we;
  endtask

  // Table word i: reg form, op=i+1, flag 0, D=A=B=i, regwe 1.
  task automatic drive_tab(input int i);
    drive(t_aluop[i], t_d[i], t_d[i], t_d[i], 16'h0000, 1'b1);
  endtask

  task automatic single(input string tag, input logic [4:0] a, input logic [2:0] d,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] im,
                        input logic we, input logic [15:0] exp_inst, input logic exp_err);
    drive(a, d, ra, rb, im, we);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check({tag, " valid"}, o_valid, 1'b1);
    check({tag, " inst"}, o_inst, exp_inst);
    check({tag, " err"}, o_err, exp_err);
    check({tag, " addr"}, o_addr, exp_addr);
    exp_addr = exp_addr + 8'd1;
    @(negedge clk);
    check({tag, " drained"}, o_valid, 1'b0);
    check({tag, " addr_next"}, o_addr, exp_addr);
  endtask

  task automatic stream(input string tag, input int nw, input int rlo_from, input int rlo_len,
                        input int elo_from, input int elo_len);
    int inn = 0;
    int outn = 0;
    int stalls = 0;
    logic prev_hold = 1'b0;
    logic [15:0] prev_inst = '0;
    logic [7:0]  prev_addr = '0;
    for (int c = 0; c < 40 && outn < nw; c++) begin
      ready = !(c >= rlo_from && c < rlo_from + rlo_len);
      en    = !(c >= elo_from && c < elo_from + elo_len);
      valid = (inn < nw);
      if (inn < nw) drive_tab(inn);
      #1;
      if (prev_hold) begin
        check({tag, " hold_valid"}, o_valid, 1'b1);
        check({tag, " hold_inst"}, o_inst, prev_inst);
        check({tag, " hold_addr"}, o_addr, prev_addr);
      end
      if (!en) begin
        check({tag, " en_lo_ready"}, o_ready, 1'b0);
        check({tag, " en_lo_wrap"}, o_wrap, 1'b0);
      end
      if (valid && !o_ready) stalls++;
      if (valid && o_ready) inn++;
      if (o_valid && ready && en) begin
        check({tag, " inst"}, o_inst, t_inst[outn]);
        check({tag, " err"}, o_err, 1'b0);
        check({tag, " addr"}, o_addr, exp_addr);
        exp_addr = exp_addr + 8'd1;
        outn++;
      end
      prev_hold = o_valid && !(ready && en);
      prev_inst = o_inst;
      prev_addr = o_addr;
      @(negedge clk);
    end
    valid = 1'b0; en = 1'b1; ready = 1'b1;
    check({tag, " words_out"}, outn, nw);
    check({tag, " input_stalled"}, stalls > 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] wexp [3];
    int wn, wraps;

    t_aluop[0] = 5'b00010; t_d[0] = 3'd0; t_inst[0] = 16'h1000;
    t_aluop[1] = 5'b00100; t_d[1] = 3'd1; t_inst[1] = 16'h2224;
    t_aluop[2] = 5'b00110; t_d[2] = 3'd2; t_inst[2] = 16'h3448;
    t_aluop[3] = 5'b01000; t_d[3] = 3'd3; t_inst[3] = 16'h466C;

    rst = 1'b1; en = 1'b1; clr = 1'b0; valid = 1'b0; ready = 1'b1;
    valid2 = 1'b0; ready2 = 1'b1;
    drive(5'd0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("rst ready", o_ready, 1'b0);
    @(negedge clk);
    check("rst valid", o_valid, 1'b0);
    check("rst inst", o_inst, 16'h0000);
    check("rst err", o_err, 1'b0);
    check("rst wrap", o_wrap, 1'b0);
    check("rst addr", o_addr, BASE);
    rst = 1'b0;
    exp_addr = BASE;
    #1;
    check("post_rst ready", o_ready, 1'b1);
    @(negedge clk);

    single("reg",     5'b00011, 3'd3, 3'd0, 3'd1, 16'h0000, 1'b1, 16'h1704, 1'b0);
    single("imm",     5'b10001, 3'd2, 3'd0, 3'd0, 16'h5A5A, 1'b1, 16'h855A, 1'b0);
    single("imm_err", 5'b10001, 3'd2, 3'd0, 3'd0, 16'h125A, 1'b1, 16'h855A, 1'b1);
    single("jmp_we",  5'b11000, 3'd2, 3'd0, 3'd0, 16'h5A5A, 1'b1, 16'hC45A, 1'b1);
    single("st_reg",  5'b10110, 3'd1, 3'd2, 3'd3, 16'h1234, 1'b0, 16'hB24C, 1'b0);

    stream("bp", 4, 3, 3, 100, 0);
    stream("en", 3, 100, 0, 2, 5);

    // Reset with two words in flight.
    drive_tab(0); valid = 1'b1;
    @(negedge clk);
    drive_tab(1);
    @(negedge clk);
    check("midrst full", o_valid, 1'b1);
    valid = 1'b0; ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst valid", o_valid, 1'b0);
    check("midrst addr", o_addr, BASE);
    rst = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("midrst dropped", o_valid, 1'b0);
    exp_addr = BASE;

    // Clear coinciding with an output transfer.
    single("pre_clr", 5'b00011, 3'd3, 3'd0, 3'd1, 16'h0000, 1'b1, 16'h1704, 1'b0);
    drive_tab(2); valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("clr pre_addr", o_addr, BASE + 8'd1);
    check("clr pre_valid", o_valid, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr addr", o_addr, BASE);
    check("clr consumed", o_valid, 1'b0);

    // Wrap on the AW=2, BASE=2 instance.
    wexp[0] = 2'd2; wexp[1] = 2'd3; wexp[2] = 2'd0;
    wn = 0; wraps = 0;
    for (int c = 0; c < 8; c++) begin
      valid2 = (c < 3);
      if (c < 3) drive_tab(c);
      #1;
      if (o_wrap2) begin
        wraps++;
        check("wrap after_addr3", wn, 2);
      end
      if (o_valid2 && ready2 && wn < 3) begin
        check("wrap inst", o_inst2, t_inst[wn]);
        check("wrap addr", o_addr2, wexp[wn]);
        wn++;
      end
      @(negedge clk);
    end
    check("wrap words", wn, 3);
    check("wrap pulses", wraps, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
